// File: rtl/mnemonic_decoder_stream.sv
// mnemonic_decoder_stream
// Streaming RV32I mnemonic decoder. ASCII characters arrive over a
// valid/ready input. Letters accumulate into a right-aligned buffer of
// MAX_LEN 5-bit codes. When a delimiter arrives, the buffer is looked up
// and {opcode, funct7, funct3} is presented on a valid/ready output. That
// output holds until the consumer takes it.
//
// Optional feature: define MNEMONIC_PSEUDO_EN to add the pseudo-instruction
// table (nop, mv, j, ret, jr, li, not).
//
// Ports
//   clk_in    clock
//   rst_n_in  synchronous reset, active low
//   abort_in  drop the token in progress (or a pending result) and go idle
//   in_valid / in_ready / in_char   character input stream
//   out_valid / out_ready           result handshake
//   opcode, funct7, funct3          decoded fields (0 on error)
//   mn_len    letters accumulated for this token
//   err       result is an error
//   err_code  0 unknown mnemonic, 1 overflow, 2 bad character
//   is_pseudo result came from the pseudo table
module mnemonic_decoder_stream #(
  parameter int MAX_LEN     = 6,
  parameter bit NL_IS_DELIM = 1'b1
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       abort_in,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_char,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [6:0] opcode,
  output logic [6:0] funct7,
  output logic [2:0] funct3,
  output logic [3:0] mn_len,
  output logic       err,
  output logic [1:0] err_code,
  output logic       is_pseudo
);

  localparam int BUF_W = MAX_LEN * 5;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  // funct7 marker for immediate-form ALU ops that have no real funct7
  localparam logic [6:0] F7_IMM    = 7'b1111111;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  localparam logic [1:0] ERR_UNKNOWN  = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW = 2'd1;
  localparam logic [1:0] ERR_BADCHAR  = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_HOLD} state_t;

  state_t           r_state;
  logic [BUF_W-1:0] r_buf;
  logic [3:0]       r_len;
  logic [1:0]       r_err_pend;
  logic             r_out_valid;
  logic [6:0]       r_opcode;
  logic [6:0]       r_funct7;
  logic [2:0]       r_funct3;
  logic [3:0]       r_mn_len;
  logic             r_err;
  logic [1:0]       r_err_code;
  logic             r_is_pseudo;

  logic        w_fire;
  logic        w_is_lower;
  logic        w_is_upper;
  logic        w_is_letter;
  logic        w_is_delim;
  logic [4:0]  w_code;
  logic [39:0] w_key40;
  logic        w_b_hit;
  logic [16:0] w_b_res;
  logic        w_p_hit;
  logic [16:0] w_p_res;

  // Packs up to five ASCII lowercase letters, right-aligned and NUL-padded,
  // into the same 5-bit-per-letter key layout as the buffer.
  function automatic logic [24:0] enc(input logic [39:0] s);
    logic [24:0] k;
    k = '0;
    for (int i = 0; i < 5; i++)
      if (s[i*8 +: 8] != 8'h00) k[i*5 +: 5] = 5'(s[i*8 +: 8] - 8'h60);
    return k;
  endfunction

  assign w_fire      = in_valid && in_ready;
  assign w_is_lower  = (in_char >= 8'h61) && (in_char <= 8'h7a);
  assign w_is_upper  = (in_char >= 8'h41) && (in_char <= 8'h5a);
  assign w_is_letter = w_is_lower || w_is_upper;
  assign w_code      = w_is_lower ? 5'(in_char - 8'h60) : 5'(in_char - 8'h40);
  assign w_is_delim  = (in_char == 8'h20) || (in_char == 8'h2c) || (in_char == 8'h09) ||
                       (NL_IS_DELIM && (in_char == 8'h0a));
  assign w_key40     = 40'(r_buf);

  // Base RV32I table. All entries are at most five letters long, so the
  // slots above the fifth must be pad for a hit.
  always_comb begin
    w_b_hit = 1'b1;
    w_b_res = '0;
    case (w_key40[24:0])
      enc(40'("lui")):   w_b_res = {OP_LUI,    7'h00,  3'b000};
      enc(40'("auipc")): w_b_res = {OP_AUIPC,  7'h00,  3'b000};
      enc(40'("jal")):   w_b_res = {OP_JAL,    7'h00,  3'b000};
      enc(40'("jalr")):  w_b_res = {OP_JALR,   7'h00,  3'b000};
      enc(40'("beq")):   w_b_res = {OP_BRANCH, 7'h00,  3'b000};
      enc(40'("bne")):   w_b_res = {OP_BRANCH, 7'h00,  3'b001};
      enc(40'("blt")):   w_b_res = {OP_BRANCH, 7'h00,  3'b100};
      enc(40'("bge")):   w_b_res = {OP_BRANCH, 7'h00,  3'b101};
      enc(40'("bltu")):  w_b_res = {OP_BRANCH, 7'h00,  3'b110};
      enc(40'("bgeu")):  w_b_res = {OP_BRANCH, 7'h00,  3'b111};
      enc(40'("lb")):    w_b_res = {OP_LOAD,   7'h00,  3'b000};
      enc(40'("lh")):    w_b_res = {OP_LOAD,   7'h00,  3'b001};
      enc(40'("lw")):    w_b_res = {OP_LOAD,   7'h00,  3'b010};
      enc(40'("lbu")):   w_b_res = {OP_LOAD,   7'h00,  3'b100};
      enc(40'("lhu")):   w_b_res = {OP_LOAD,   7'h00,  3'b101};
      enc(40'("sb")):    w_b_res = {OP_STORE,  7'h00,  3'b000};
      enc(40'("sh")):    w_b_res = {OP_STORE,  7'h00,  3'b001};
      enc(40'("sw")):    w_b_res = {OP_STORE,  7'h00,  3'b010};
      enc(40'("addi")):  w_b_res = {OP_IMM,    F7_IMM, 3'b000};
      enc(40'("slti")):  w_b_res = {OP_IMM,    F7_IMM, 3'b010};
      enc(40'("sltiu")): w_b_res = {OP_IMM,    F7_IMM, 3'b011};
      enc(40'("xori")):  w_b_res = {OP_IMM,    F7_IMM, 3'b100};
      enc(40'("ori")):   w_b_res = {OP_IMM,    F7_IMM, 3'b110};
      enc(40'("andi")):  w_b_res = {OP_IMM,    F7_IMM, 3'b111};
      enc(40'("slli")):  w_b_res = {OP_IMM,    7'h00,  3'b001};
      enc(40'("srli")):  w_b_res = {OP_IMM,    7'h00,  3'b101};
      enc(40'("srai")):  w_b_res = {OP_IMM,    F7_ALT, 3'b101};
      enc(40'("add")):   w_b_res = {OP_OP,     7'h00,  3'b000};
      enc(40'("sub")):   w_b_res = {OP_OP,     F7_ALT, 3'b000};
      enc(40'("sll")):   w_b_res = {OP_OP,     7'h00,  3'b001};
      enc(40'("slt")):   w_b_res = {OP_OP,     7'h00,  3'b010};
      enc(40'("sltu")):  w_b_res = {OP_OP,     7'h00,  3'b011};
      enc(40'("xor")):   w_b_res = {OP_OP,     7'h00,  3'b100};
      enc(40'("srl")):   w_b_res = {OP_OP,     7'h00,  3'b101};
      enc(40'("sra")):   w_b_res = {OP_OP,     F7_ALT, 3'b101};
      enc(40'("or")):    w_b_res = {OP_OP,     7'h00,  3'b110};
      enc(40'("and")):   w_b_res = {OP_OP,     7'h00,  3'b111};
      default:           w_b_hit = 1'b0;
    endcase
    if (w_key40[39:25] != '0) w_b_hit = 1'b0;
  end

`ifdef MNEMONIC_PSEUDO_EN
  always_comb begin
    w_p_hit = 1'b1;
    w_p_res = '0;
    case (w_key40[24:0])
      enc(40'("nop")): w_p_res = {OP_IMM,  F7_IMM, 3'b000};
      enc(40'("mv")):  w_p_res = {OP_IMM,  F7_IMM, 3'b000};
      enc(40'("j")):   w_p_res = {OP_JAL,  7'h00,  3'b000};
      enc(40'("ret")): w_p_res = {OP_JALR, 7'h00,  3'b000};
      enc(40'("jr")):  w_p_res = {OP_JALR, 7'h00,  3'b000};
      enc(40'("li")):  w_p_res = {OP_IMM,  F7_IMM, 3'b000};
      enc(40'("not")): w_p_res = {OP_IMM,  F7_IMM, 3'b100};
      default:         w_p_hit = 1'b0;
    endcase
    if (w_key40[39:25] != '0) w_p_hit = 1'b0;
  end
`else
  assign w_p_hit = 1'b0;
  assign w_p_res = '0;
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state     <= S_IDLE;
      r_buf       <= '0;
      r_len       <= '0;
      r_err_pend  <= ERR_UNKNOWN;
      r_out_valid <= 1'b0;
      r_opcode    <= '0;
      r_funct7    <= '0;
      r_funct3    <= '0;
      r_mn_len    <= '0;
      r_err       <= 1'b0;
      r_err_code  <= '0;
      r_is_pseudo <= 1'b0;
    end else if (abort_in) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_fire) begin
          if (w_is_letter) begin
            r_buf   <= BUF_W'(w_code);
            r_len   <= 4'd1;
            r_state <= S_ACCUM;
          end else if (!w_is_delim) begin
            r_len      <= '0;
            r_err_pend <= ERR_BADCHAR;
            r_state    <= S_DRAIN;
          end
        end
        S_ACCUM: if (w_fire) begin
          if (w_is_letter && (r_len < 4'(MAX_LEN))) begin
            r_buf <= {r_buf[BUF_W-6:0], w_code};
            r_len <= r_len + 4'd1;
          end else if (w_is_letter) begin
            r_err_pend <= ERR_OVERFLOW;
            r_state    <= S_DRAIN;
          end else if (w_is_delim) begin
            r_out_valid <= 1'b1;
            r_mn_len    <= r_len;
            r_err_code  <= ERR_UNKNOWN;
            r_state     <= S_HOLD;
            if (w_b_hit) begin
              {r_opcode, r_funct7, r_funct3} <= w_b_res;
              r_err       <= 1'b0;
              r_is_pseudo <= 1'b0;
            end else if (w_p_hit) begin
              {r_opcode, r_funct7, r_funct3} <= w_p_res;
              r_err       <= 1'b0;
              r_is_pseudo <= 1'b1;
            end else begin
              {r_opcode, r_funct7, r_funct3} <= '0;
              r_err       <= 1'b1;
              r_is_pseudo <= 1'b0;
            end
          end else begin
            r_err_pend <= ERR_BADCHAR;
            r_state    <= S_DRAIN;
          end
        end
        // The first error seen is kept; further bad characters are swallowed.
        S_DRAIN: if (w_fire && w_is_delim) begin
          r_out_valid                    <= 1'b1;
          r_mn_len                       <= r_len;
          r_err                          <= 1'b1;
          r_err_code                     <= r_err_pend;
          r_is_pseudo                    <= 1'b0;
          {r_opcode, r_funct7, r_funct3} <= '0;
          r_state                        <= S_HOLD;
        end
        S_HOLD: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state != S_HOLD);
  assign out_valid = r_out_valid;
  assign opcode    = r_opcode;
  assign funct7    = r_funct7;
  assign funct3    = r_funct3;
  assign mn_len    = r_mn_len;
  assign err       = r_err;
  assign err_code  = r_err_code;
  assign is_pseudo = r_is_pseudo;

endmodule

// File: tb/tb_mnemonic_decoder_stream.sv
// Testbench for mnemonic_decoder_stream (MAX_LEN=6, NL_IS_DELIM=1).
// Directed character streams with hand-computed decode results.
module tb_mnemonic_decoder_stream;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic       clk_in = 1'b0;
  logic       rst_n_in, abort_in, in_valid, out_ready;
  logic [7:0] in_char;
  logic       in_ready, out_valid, err, is_pseudo;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [3:0] mn_len;
  logic [1:0] err_code;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_in = ~clk_in;

  mnemonic_decoder_stream dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .abort_in(abort_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .funct7(funct7), .funct3(funct3), .mn_len(mn_len),
    .err(err), .err_code(err_code), .is_pseudo(is_pseudo)
  );

  // Full result view and the same view without mn_len (for error results).
  logic [25:0] obs;
  logic [21:0] obs_e;
  assign obs   = {out_valid, err, err_code, opcode, funct7, funct3, mn_len, is_pseudo};
  assign obs_e = {out_valid, err, err_code, opcode, funct7, funct3, is_pseudo};

  function automatic logic [25:0] exp_ok(input logic [6:0] op, input logic [6:0] f7,
                                         input logic [2:0] f3, input logic [3:0] len,
                                         input logic ps);
    return {1'b1, 1'b0, 2'b00, op, f7, f3, len, ps};
  endfunction

  function automatic logic [21:0] exp_err(input logic [1:0] code);
    return {1'b1, 1'b1, code, 7'h00, 7'h00, 3'b000, 1'b0};
  endfunction

  task automatic step();
    @(posedge clk_in); #1;
  endtask

  task automatic send(input logic [7:0] c);
    in_char  = c;
    in_valid = 1'b1;
    @(posedge clk_in); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0; abort_in = 1'b0; in_valid = 1'b0; in_char = 8'h00; out_ready = 1'b0;
    step(); step();
    n_cmp++;
    if ({in_ready, obs} !== {1'b1, 26'h0}) begin
      n_fail++; $display("FAIL reset_state got %h want %h", {in_ready, obs}, {1'b1, 26'h0});
    end
    rst_n_in = 1'b1;
    step();
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    send_str("add");
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL add_before_delim got %b want 0", out_valid);
    end
    send(8'h20);
    n_cmp++;
    if (obs !== exp_ok(OP_OP, 7'h00, 3'b000, 4'd3, 1'b0)) begin
      n_fail++; $display("FAIL add_result got %h want %h", obs, exp_ok(OP_OP, 7'h00, 3'b000, 4'd3, 1'b0));
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL add_in_ready_hold got %b want 0", in_ready);
    end
    step();
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL add_consumed got %b want 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_backpressure();
    logic [25:0] e;
    e = exp_ok(OP_IMM, 7'b0100000, 3'b101, 4'd4, 1'b0);
    out_ready = 1'b0;
    send_str("  SRAI,");
    n_cmp++;
    if (obs !== e) begin
      n_fail++; $display("FAIL srai_result got %h want %h", obs, e);
    end
    for (int k = 0; k < 5; k++) begin
      in_char = 8'h2c; in_valid = 1'b1;
      step();
      n_cmp++;
      if ({in_ready, obs} !== {1'b0, e}) begin
        n_fail++; $display("FAIL srai_hold cycle %0d got %h want %h", k, {in_ready, obs}, {1'b0, e});
      end
    end
    // A letter offered in the release cycle must not be taken.
    in_char = 8'h78; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL srai_release got %b want 01", {out_valid, in_ready});
    end
    send_str("sub ");
    n_cmp++;
    if (obs !== exp_ok(OP_OP, 7'b0100000, 3'b000, 4'd3, 1'b0)) begin
      n_fail++; $display("FAIL sub_after_release got %h want %h", obs, exp_ok(OP_OP, 7'b0100000, 3'b000, 4'd3, 1'b0));
    end
    step();
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    send_str("sltiuxx");
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL ovf_before_delim got %b want 0", out_valid);
    end
    send(8'h20);
    n_cmp++;
    if (obs_e !== exp_err(2'd1)) begin
      n_fail++; $display("FAIL ovf_result got %h want %h", obs_e, exp_err(2'd1));
    end
    out_ready = 1'b1;
    step();
    send_str("or ");
    n_cmp++;
    if (obs !== exp_ok(OP_OP, 7'h00, 3'b110, 4'd2, 1'b0)) begin
      n_fail++; $display("FAIL or_after_ovf got %h want %h", obs, exp_ok(OP_OP, 7'h00, 3'b110, 4'd2, 1'b0));
    end
    step();
  endtask

  task automatic test_errors();
    out_ready = 1'b1;
    send_str("ad3d ");
    n_cmp++;
    if (obs_e !== exp_err(2'd2)) begin
      n_fail++; $display("FAIL badchar got %h want %h", obs_e, exp_err(2'd2));
    end
    step();
    send_str("abcdefg3 ");
    n_cmp++;
    if (obs_e !== exp_err(2'd1)) begin
      n_fail++; $display("FAIL ovf_then_bad got %h want %h", obs_e, exp_err(2'd1));
    end
    step();
    send_str("a3bcdefgh ");
    n_cmp++;
    if (obs_e !== exp_err(2'd2)) begin
      n_fail++; $display("FAIL bad_then_long got %h want %h", obs_e, exp_err(2'd2));
    end
    step();
    send_str("foo ");
    n_cmp++;
    if (obs_e !== exp_err(2'd0)) begin
      n_fail++; $display("FAIL unknown got %h want %h", obs_e, exp_err(2'd0));
    end
    step();
  endtask

  task automatic test_delims();
    out_ready = 1'b1;
    send_str("beq\n");
    n_cmp++;
    if (obs !== exp_ok(OP_BRANCH, 7'h00, 3'b000, 4'd3, 1'b0)) begin
      n_fail++; $display("FAIL beq_newline got %h want %h", obs, exp_ok(OP_BRANCH, 7'h00, 3'b000, 4'd3, 1'b0));
    end
    step();
    send_str("\tJaL\t");
    n_cmp++;
    if (obs !== exp_ok(OP_JAL, 7'h00, 3'b000, 4'd3, 1'b0)) begin
      n_fail++; $display("FAIL jal_tab got %h want %h", obs, exp_ok(OP_JAL, 7'h00, 3'b000, 4'd3, 1'b0));
    end
    step();
    send_str("addi ");
    n_cmp++;
    if (obs !== exp_ok(OP_IMM, 7'h7f, 3'b000, 4'd4, 1'b0)) begin
      n_fail++; $display("FAIL addi got %h want %h", obs, exp_ok(OP_IMM, 7'h7f, 3'b000, 4'd4, 1'b0));
    end
    step();
  endtask

  task automatic test_abort_reset();
    out_ready = 1'b1;
    send_str("ad");
    abort_in = 1'b1;
    step();
    abort_in = 1'b0;
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL abort_accum got %b want 01", {out_valid, in_ready});
    end
    send_str("add ");
    n_cmp++;
    if (obs !== exp_ok(OP_OP, 7'h00, 3'b000, 4'd3, 1'b0)) begin
      n_fail++; $display("FAIL add_after_abort got %h want %h", obs, exp_ok(OP_OP, 7'h00, 3'b000, 4'd3, 1'b0));
    end
    step();
    out_ready = 1'b0;
    send_str("lw ");
    n_cmp++;
    if (obs !== exp_ok(OP_LOAD, 7'h00, 3'b010, 4'd2, 1'b0)) begin
      n_fail++; $display("FAIL lw_result got %h want %h", obs, exp_ok(OP_LOAD, 7'h00, 3'b010, 4'd2, 1'b0));
    end
    abort_in = 1'b1;
    step();
    abort_in = 1'b0;
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL abort_hold got %b want 01", {out_valid, in_ready});
    end
    out_ready = 1'b1;
    send_str("bn");
    rst_n_in = 1'b0;
    step();
    rst_n_in = 1'b1;
    n_cmp++;
    if ({in_ready, obs} !== {1'b1, 26'h0}) begin
      n_fail++; $display("FAIL reset_mid_token got %h want %h", {in_ready, obs}, {1'b1, 26'h0});
    end
    send_str("bne ");
    n_cmp++;
    if (obs !== exp_ok(OP_BRANCH, 7'h00, 3'b001, 4'd3, 1'b0)) begin
      n_fail++; $display("FAIL bne_after_reset got %h want %h", obs, exp_ok(OP_BRANCH, 7'h00, 3'b001, 4'd3, 1'b0));
    end
    step();
  endtask

  task automatic test_pseudo();
    out_ready = 1'b1;
    send_str("nop ");
`ifdef MNEMONIC_PSEUDO_EN
    n_cmp++;
    if (obs !== exp_ok(OP_IMM, 7'h7f, 3'b000, 4'd3, 1'b1)) begin
      n_fail++; $display("FAIL nop_pseudo got %h want %h", obs, exp_ok(OP_IMM, 7'h7f, 3'b000, 4'd3, 1'b1));
    end
`else
    n_cmp++;
    if (obs_e !== exp_err(2'd0)) begin
      n_fail++; $display("FAIL nop_unknown got %h want %h", obs_e, exp_err(2'd0));
    end
`endif
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_backpressure();
    test_overflow();
    test_errors();
    test_delims();
    test_abort_reset();
    test_pseudo();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
